branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have one clock and one reset: synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 br_valid  in  1  decoded branch offered by ID.
REQ-005 br_op  in  NPCOp_WIDTH  decoded NPCOp (PLUS4/B/BC/BCCTR/BCLR).
REQ-006 br_lk, br_bo2  in  1 each  LK bit; BO[2] (1 = CTR not decremented).
REQ-007 br_need_cr, br_need_ctr, br_need_lr  in  1 each  operand-use flags.
REQ-008 cr_iss, ctr_iss, lr_iss  in  1 each  producer issued a pending write to CR/CTR/LR.
REQ-009 cr_done, ctr_done, lr_done  in  1 each  that pending write committed.
REQ-010 br_ready  out  1  controller accepts a branch this cycle.
REQ-011 npc_op  out  NPCOp_WIDTH  Op driven into the NPC datapath.
REQ-012 pc_wr  out  1  PC register update enable.
REQ-013 if_stall, flush  out  1 each  hold IF/ID; kill fetched slot.
REQ-014 ctr_we, lr_we  out  1 each  commit CTRwd/LRwd from the NPC datapath.
REQ-015 scb_full  out  3  per-resource pending counter at max {cr,ctr,lr}.

Function
REQ-016 SHALL keep one 3-bit pending counter per resource: +1 on iss, -1 on done, unchanged on both.
REQ-017 Counter at 7 with iss and no done SHALL hold 7; at 0 with done and no iss SHALL hold 0; scb_full[i] = (cnt==7).
REQ-018 hazard SHALL be (need_cr&cnt_cr!=0)|(need_ctr&cnt_ctr!=0)|(need_lr&cnt_lr!=0), evaluated on registered counts and captured need flags.
REQ-019 States SHALL be IDLE, WAIT, EXEC, FLUSH.
REQ-020 IDLE: br_ready=1; br_valid with br_op!=PLUS4 SHALL capture op/lk/bo2/need flags and go to WAIT if hazard (using the incoming need flags), else EXEC; br_op==PLUS4 is ignored.
REQ-021 WAIT: br_ready=0, if_stall=1, pc_wr=0; go to EXEC in the cycle after hazard is first seen clear.
REQ-022 EXEC (exactly 1 cycle): npc_op=captured op, pc_wr=1, flush=1, if_stall=1; lr_we=captured lk; ctr_we=~bo2 for BC/BCLR, 0 for B/BCCTR; go to FLUSH.
REQ-023 FLUSH (exactly 1 cycle): flush=1, if_stall=0, pc_wr=1, npc_op=PLUS4; go to IDLE.
REQ-024 Outside EXEC npc_op SHALL be NPCOp_PLUS4; in IDLE pc_wr=1, flush=0, if_stall=0, ctr_we=lr_we=0.
REQ-025 Hazard-free latency: accept at T, EXEC at T+1, FLUSH at T+2, br_ready=1 at T+3.
REQ-026 Counters SHALL keep updating in every state, including WAIT and EXEC.

Reset
REQ-027 rst SHALL force state IDLE, all counters 0, captured fields 0, regardless of state.
REQ-028 Outputs in the first cycle after reset: br_ready=1, npc_op=PLUS4, pc_wr=1, all other outputs 0.
REQ-029 A branch in WAIT/EXEC/FLUSH at reset SHALL be discarded; no ctr_we/lr_we pulse.

Structure
REQ-030 NPCOp encodings SHALL come from the shared control-encode header; state encoding and SCB_CNT_WIDTH=3 SHALL be added to the same shared header.
REQ-031 One sub-module, pend_cnt (saturating up/down counter with full flag), SHALL be instantiated three times.

Verification
REQ-032 Reset, br_valid=1, op=B, lk=1, no pending -> EXEC next cycle: npc_op=B, pc_wr=1, lr_we=1, ctr_we=0; FLUSH; br_ready=1 three cycles after accept.
REQ-033 ctr_iss pulse, then BC with bo2=0, need_ctr=1 -> WAIT until ctr_done; EXEC the cycle after count reaches 0 with ctr_we=1.
REQ-034 ctr_iss 8 times, no done -> cnt_ctr=7, scb_full[1]=1; then ctr_iss+ctr_done together -> count stays 7.
REQ-035 BCLR while in WAIT on cr; assert rst -> next cycle IDLE, counts 0, no lr_we/ctr_we pulse ever.
REQ-036 br_valid=1, op=PLUS4 in IDLE -> state stays IDLE, br_ready=1, flush=0.
REQ-037 BCCTR with bo2=0 -> EXEC ctr_we=0, npc_op=BCCTR.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared control-encode definitions for the branch controller slice.
// Holds the NPC datapath op encodings, the branch controller state
// encoding, the scoreboard counter width and the captured-branch record.
package branch_ctrl_pkg;

    // NPC datapath op encodings
    localparam int NPCOp_WIDTH = 3;
    localparam logic [NPCOp_WIDTH-1:0] NPCOp_PLUS4 = 3'd0;
    localparam logic [NPCOp_WIDTH-1:0] NPCOp_B     = 3'd1;
    localparam logic [NPCOp_WIDTH-1:0] NPCOp_BC    = 3'd2;
    localparam logic [NPCOp_WIDTH-1:0] NPCOp_BCCTR = 3'd3;
    localparam logic [NPCOp_WIDTH-1:0] NPCOp_BCLR  = 3'd4;

    // Per-resource pending-write counter width
    localparam int SCB_CNT_WIDTH = 3;

    // Branch controller state encoding
    localparam int BR_ST_WIDTH = 2;
    localparam logic [BR_ST_WIDTH-1:0] BR_IDLE  = 2'd0;
    localparam logic [BR_ST_WIDTH-1:0] BR_WAIT  = 2'd1;
    localparam logic [BR_ST_WIDTH-1:0] BR_EXEC  = 2'd2;
    localparam logic [BR_ST_WIDTH-1:0] BR_FLUSH = 2'd3;

    // Fields of an accepted branch held until it executes
    typedef struct packed {
        logic [NPCOp_WIDTH-1:0] op;
        logic                   lk;
        logic                   bo2;
        logic                   need_cr;
        logic                   need_ctr;
        logic                   need_lr;
    } br_cap_t;

    // Conditional branches decrement CTR unless BO[2] says otherwise
    function automatic logic op_decrements_ctr(input logic [NPCOp_WIDTH-1:0] op);
        return (op == NPCOp_BC) || (op == NPCOp_BCLR);
    endfunction

endpackage

// File: rtl/branch_ctrl_pend_cnt.sv
// pend_cnt: saturating up/down counter of outstanding writes to one
// architectural resource.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   iss      : a producer issued a pending write (+1)
//   done     : a pending write committed (-1)
//   cnt      : current pending count
//   full     : count is at its maximum value
module pend_cnt
    import branch_ctrl_pkg::*;
#(
    parameter int WIDTH = SCB_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss,
    input  logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic             full
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    // iss and done together cancel; both ends saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (iss && !done && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (done && !iss && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full = (cnt == CNT_MAX);

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: accepts decoded branches from ID, waits for pending
// CR/CTR/LR writes to drain, then drives one execute cycle into the NPC
// datapath followed by one flush cycle.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   br_valid, br_op, br_lk, br_bo2    : decoded branch offered by ID
//   br_need_cr/ctr/lr                 : operand-use flags of that branch
//   cr/ctr/lr_iss, cr/ctr/lr_done     : pending-write issue / commit events
//   br_ready                          : branch accepted this cycle
//   npc_op                            : op driven into the NPC datapath
//   pc_wr, if_stall, flush            : PC enable, IF/ID hold, slot kill
//   ctr_we, lr_we                     : commit CTR / LR from the NPC datapath
//   scb_full                          : {lr, ctr, cr} pending counter at max
module branch_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   br_valid,
    input  logic [NPCOp_WIDTH-1:0] br_op,
    input  logic                   br_lk,
    input  logic                   br_bo2,
    input  logic                   br_need_cr,
    input  logic                   br_need_ctr,
    input  logic                   br_need_lr,
    input  logic                   cr_iss,
    input  logic                   ctr_iss,
    input  logic                   lr_iss,
    input  logic                   cr_done,
    input  logic                   ctr_done,
    input  logic                   lr_done,
    output logic                   br_ready,
    output logic [NPCOp_WIDTH-1:0] npc_op,
    output logic                   pc_wr,
    output logic                   if_stall,
    output logic                   flush,
    output logic                   ctr_we,
    output logic                   lr_we,
    output logic [2:0]             scb_full
);

    logic [BR_ST_WIDTH-1:0]   state;
    logic [BR_ST_WIDTH-1:0]   state_nxt;
    br_cap_t                  cap;
    br_cap_t                  cap_in;
    logic [SCB_CNT_WIDTH-1:0] cnt_cr;
    logic [SCB_CNT_WIDTH-1:0] cnt_ctr;
    logic [SCB_CNT_WIDTH-1:0] cnt_lr;
    logic                     accept;
    logic                     hazard_in;
    logic                     hazard;

    pend_cnt #(.WIDTH(SCB_CNT_WIDTH)) u_cnt_cr (
        .clk  (clk),
        .rst  (rst),
        .iss  (cr_iss),
        .done (cr_done),
        .cnt  (cnt_cr),
        .full (scb_full[0])
    );

    pend_cnt #(.WIDTH(SCB_CNT_WIDTH)) u_cnt_ctr (
        .clk  (clk),
        .rst  (rst),
        .iss  (ctr_iss),
        .done (ctr_done),
        .cnt  (cnt_ctr),
        .full (scb_full[1])
    );

    pend_cnt #(.WIDTH(SCB_CNT_WIDTH)) u_cnt_lr (
        .clk  (clk),
        .rst  (rst),
        .iss  (lr_iss),
        .done (lr_done),
        .cnt  (cnt_lr),
        .full (scb_full[2])
    );

    always_comb begin
        cap_in          = '0;
        cap_in.op       = br_op;
        cap_in.lk       = br_lk;
        cap_in.bo2      = br_bo2;
        cap_in.need_cr  = br_need_cr;
        cap_in.need_ctr = br_need_ctr;
        cap_in.need_lr  = br_need_lr;
    end

    // PLUS4 is plain sequential fetch and never enters the controller
    assign accept = (state == BR_IDLE) && br_valid && (br_op != NPCOp_PLUS4);

    // At accept time the incoming flags decide; afterwards the captured ones
    assign hazard_in = (br_need_cr  && (cnt_cr  != '0)) ||
                       (br_need_ctr && (cnt_ctr != '0)) ||
                       (br_need_lr  && (cnt_lr  != '0));

    assign hazard    = (cap.need_cr  && (cnt_cr  != '0)) ||
                       (cap.need_ctr && (cnt_ctr != '0)) ||
                       (cap.need_lr  && (cnt_lr  != '0));

    always_comb begin
        state_nxt = state;
        case (state)
            BR_IDLE:  if (accept) state_nxt = hazard_in ? BR_WAIT : BR_EXEC;
            BR_WAIT:  if (!hazard) state_nxt = BR_EXEC;
            BR_EXEC:  state_nxt = BR_FLUSH;
            BR_FLUSH: state_nxt = BR_IDLE;
            default:  state_nxt = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BR_IDLE;
            cap   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap <= cap_in;
            end
        end
    end

    // Write enables are masked by rst so a branch killed by reset while
    // in EXEC never commits CTR/LR.
    always_comb begin
        br_ready = 1'b0;
        npc_op   = NPCOp_PLUS4;
        pc_wr    = 1'b1;
        if_stall = 1'b0;
        flush    = 1'b0;
        ctr_we   = 1'b0;
        lr_we    = 1'b0;
        case (state)
            BR_IDLE: begin
                br_ready = 1'b1;
            end
            BR_WAIT: begin
                pc_wr    = 1'b0;
                if_stall = 1'b1;
            end
            BR_EXEC: begin
                npc_op   = cap.op;
                if_stall = 1'b1;
                flush    = 1'b1;
                lr_we    = cap.lk && !rst;
                ctr_we   = op_decrements_ctr(cap.op) && !cap.bo2 && !rst;
            end
            BR_FLUSH: begin
                flush    = 1'b1;
            end
            default: begin
                br_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_branch_ctrl;

    logic       clk;
    logic       rst;
    logic       br_valid;
    logic [2:0] br_op;
    logic       br_lk, br_bo2;
    logic       br_need_cr, br_need_ctr, br_need_lr;
    logic       cr_iss, ctr_iss, lr_iss;
    logic       cr_done, ctr_done, lr_done;
    logic       br_ready;
    logic [2:0] npc_op;
    logic       pc_wr, if_stall, flush, ctr_we, lr_we;
    logic [2:0] scb_full;

    int tests_run    = 0;
    int tests_failed = 0;

    // model: mode 0 = idle, 1 = waiting, 2 = executing, 3 = flushing
    int       m_mode;
    int       m_cnt[3];
    int       m_op;
    bit       m_lk, m_bo2;
    bit       m_need[3];

    branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .br_valid    (br_valid),
        .br_op       (br_op),
        .br_lk       (br_lk),
        .br_bo2      (br_bo2),
        .br_need_cr  (br_need_cr),
        .br_need_ctr (br_need_ctr),
        .br_need_lr  (br_need_lr),
        .cr_iss      (cr_iss),
        .ctr_iss     (ctr_iss),
        .lr_iss      (lr_iss),
        .cr_done     (cr_done),
        .ctr_done    (ctr_done),
        .lr_done     (lr_done),
        .br_ready    (br_ready),
        .npc_op      (npc_op),
        .pc_wr       (pc_wr),
        .if_stall    (if_stall),
        .flush       (flush),
        .ctr_we      (ctr_we),
        .lr_we       (lr_we),
        .scb_full    (scb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]  = 0;
            m_need[i] = 0;
        end
        m_op  = 0;
        m_lk  = 0;
        m_bo2 = 0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model at
    // the rising edge, then return 1 time unit later for the next stimulus.
    task automatic step();
        bit  iss[3];
        bit  dn[3];
        bit  haz;
        int  e_npc;
        @(negedge clk);
        e_npc = (m_mode == 2) ? m_op : 0;
        check("br_ready", br_ready, (m_mode == 0));
        check("npc_op",   npc_op,   e_npc);
        check("pc_wr",    pc_wr,    (m_mode != 1));
        check("if_stall", if_stall, (m_mode == 1 || m_mode == 2));
        check("flush",    flush,    (m_mode >= 2));
        check("lr_we",    lr_we,    (m_mode == 2 && !rst && m_lk));
        check("ctr_we",   ctr_we,   (m_mode == 2 && !rst && !m_bo2 && (m_op == 2 || m_op == 4)));
        check("scb_full", scb_full, {29'd0, m_cnt[2] == 7, m_cnt[1] == 7, m_cnt[0] == 7});
        @(posedge clk);
        iss = '{cr_iss, ctr_iss, lr_iss};
        dn  = '{cr_done, ctr_done, lr_done};
        if (rst) begin
            model_reset();
        end else begin
            haz = 0;
            for (int i = 0; i < 3; i++) if (m_need[i] && m_cnt[i] > 0) haz = 1;
            if (m_mode == 0) begin
                if (br_valid && br_op != 3'd0) begin
                    m_op   = int'(br_op);
                    m_lk   = br_lk;
                    m_bo2  = br_bo2;
                    m_need = '{br_need_cr, br_need_ctr, br_need_lr};
                    haz = 0;
                    for (int i = 0; i < 3; i++) if (m_need[i] && m_cnt[i] > 0) haz = 1;
                    m_mode = haz ? 1 : 2;
                end
            end else if (m_mode == 1) begin
                if (!haz) m_mode = 2;
            end else if (m_mode == 2) begin
                m_mode = 3;
            end else begin
                m_mode = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (iss[i] && !dn[i] && m_cnt[i] < 7) m_cnt[i]++;
                if (dn[i] && !iss[i] && m_cnt[i] > 0) m_cnt[i]--;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        br_valid = 0; br_op = 3'd0; br_lk = 0; br_bo2 = 0;
        br_need_cr = 0; br_need_ctr = 0; br_need_lr = 0;
        cr_iss = 0; ctr_iss = 0; lr_iss = 0;
        cr_done = 0; ctr_done = 0; lr_done = 0;
    endtask

    task automatic offer(input logic [2:0] op, input logic lk, input logic bo2,
                         input logic ncr, input logic nctr, input logic nlr);
        br_valid = 1; br_op = op; br_lk = lk; br_bo2 = bo2;
        br_need_cr = ncr; br_need_ctr = nctr; br_need_lr = nlr;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        check("rst_ready", br_ready, 1);
        check("rst_npc",   npc_op,   0);
        check("rst_pc_wr", pc_wr,    1);
        check("rst_flush", flush,    0);
        check("rst_full",  scb_full, 0);

        // Hazard-free B with link
        offer(3'd1, 1, 0, 0, 0, 0);
        step();
        idle_inputs();
        check("b_exec_npc", npc_op, 3'd1);
        check("b_exec_lr",  lr_we,  1);
        check("b_exec_ctr", ctr_we, 0);
        check("b_exec_pc",  pc_wr,  1);
        step();
        check("b_flush",    flush,    1);
        check("b_flush_rd", br_ready, 0);
        step();
        check("b_ready_t3", br_ready, 1);

        // BC waits on a pending CTR write
        ctr_iss = 1;
        step();
        idle_inputs();
        offer(3'd2, 0, 0, 0, 1, 0);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("bc_wait_stall", if_stall, 1);
            step();
        end
        ctr_done = 1;
        step();
        idle_inputs();
        check("bc_wait_last", pc_wr, 0);
        step();
        check("bc_exec_ctr", ctr_we, 1);
        check("bc_exec_npc", npc_op, 3'd2);
        step();
        step();

        // CTR counter saturation at 7
        ctr_iss = 1;
        for (int i = 0; i < 8; i++) step();
        check("sat_full", scb_full, 3'b010);
        ctr_done = 1;
        step();
        check("sat_both", scb_full, 3'b010);
        ctr_iss = 0;
        step();
        check("sat_dec", scb_full, 3'b000);
        for (int i = 0; i < 8; i++) step();
        idle_inputs();
        offer(3'd2, 0, 1, 0, 1, 0);
        step();
        idle_inputs();
        check("drained_exec", pc_wr,  1);
        check("drained_flsh", flush,  1);
        check("bo2_no_ctr",   ctr_we, 0);
        step();
        step();

        // Reset while a BCLR waits on CR
        cr_iss = 1;
        step();
        idle_inputs();
        offer(3'd4, 1, 0, 1, 0, 0);
        step();
        idle_inputs();
        step();
        step();
        rst = 1;
        check("rst_wait_lr", lr_we, 0);
        step();
        rst = 0;
        check("post_rst_ready", br_ready, 1);
        check("post_rst_full",  scb_full, 0);
        offer(3'd2, 0, 0, 1, 0, 0);
        step();
        idle_inputs();
        check("post_rst_exec", pc_wr,  1);
        check("post_rst_stal", if_stall, 1);
        step();
        step();

        // PLUS4 offered in IDLE is ignored
        offer(3'd0, 1, 0, 1, 1, 1);
        step();
        idle_inputs();
        check("plus4_ready", br_ready, 1);
        check("plus4_flush", flush,    0);

        // BCCTR never writes CTR
        offer(3'd3, 0, 0, 0, 0, 0);
        step();
        idle_inputs();
        check("bcctr_npc", npc_op, 3'd3);
        check("bcctr_ctr", ctr_we, 0);
        step();
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom % 50) == 0;
            br_valid    = ($urandom % 3) == 0;
            br_op       = 3'($urandom % 5);
            br_lk       = 1'($urandom);
            br_bo2      = 1'($urandom);
            br_need_cr  = 1'($urandom);
            br_need_ctr = 1'($urandom);
            br_need_lr  = 1'($urandom);
            cr_iss      = ($urandom % 3) == 0;
            ctr_iss     = ($urandom % 3) == 0;
            lr_iss      = ($urandom % 4) == 0;
            cr_done     = ($urandom % 3) == 0;
            ctr_done    = ($urandom % 3) == 0;
            lr_done     = ($urandom % 3) == 0;
            step();
        end
        rst = 0;
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
